// File: rtl/gpu_rect_writer.sv
// Rectangle write controller: walks a clipped (x, y, w, h) window row by row and strobes
// solid-colour or streamed pixels into the SDRAM system write port, paced by WR_DIV.
module gpu_rect_writer #(
    parameter int unsigned H_DISP = 1024,
    parameter int unsigned V_DISP = 600,
    parameter int unsigned PIX_W  = 24,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned WR_DIV = 2
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [15:0]      i_cmd_xpos,
    input  logic [15:0]      i_cmd_ypos,
    input  logic [LEN_W-1:0] i_cmd_width,
    input  logic [LEN_W-1:0] i_cmd_height,
    input  logic             i_cmd_mode,
    input  logic [PIX_W-1:0] i_cmd_color,
    input  logic             i_cmd_abort,
    input  logic             i_pix_valid,
    input  logic [PIX_W-1:0] i_pix_data,
    output logic             o_pix_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    input  logic             i_sysVaild,
    output logic             o_sysLoad,
    output logic [PIX_W-1:0] o_sysData,
    output logic             o_sysWriteEnable,
    output logic [31:0]      o_sysAddrMin,
    output logic [31:0]      o_sysAddrMax
);
    localparam int unsigned       PACE_W      = (WR_DIV > 1) ? $clog2(WR_DIV) : 1;
    localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(WR_DIV - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StSettle, StWrite, StDone} state_e;

    state_e            r_state, w_state_next;
    logic [15:0]       r_x, r_y;
    logic [LEN_W-1:0]  r_wc, r_hc, r_row, r_col;
    logic              r_mode, r_err, r_we;
    logic [PIX_W-1:0]  r_color, r_data;
    logic [PACE_W-1:0] r_pace;
    logic [31:0]       r_addr_min, r_addr_max;

    logic [15:0]      w_avail_x, w_avail_y;
    logic [LEN_W-1:0] w_wc, w_hc, w_ld_wc;
    logic             w_reject, w_beat, w_row_end, w_last_row, w_from_idle;
    logic [15:0]      w_ld_x;
    logic [31:0]      w_ld_row_y, w_ld_min;

    // Clip against the display edge in 16-bit arithmetic.
    assign w_avail_x = 16'(H_DISP) - i_cmd_xpos;
    assign w_avail_y = 16'(V_DISP) - i_cmd_ypos;
    assign w_wc = (32'(i_cmd_width) < 32'(w_avail_x)) ? i_cmd_width : LEN_W'(w_avail_x);
    assign w_hc = (32'(i_cmd_height) < 32'(w_avail_y)) ? i_cmd_height : LEN_W'(w_avail_y);
    assign w_reject = (32'(i_cmd_xpos) >= H_DISP) || (32'(i_cmd_ypos) >= V_DISP) ||
                      (i_cmd_width == '0) || (i_cmd_height == '0);

    assign w_beat = (r_state == StWrite) && (r_pace == '0) && i_sysVaild &&
                    (!r_mode || i_pix_valid);
    assign w_row_end  = w_beat && (r_col == r_wc - LEN_W'(1));
    assign w_last_row = (r_row == r_hc - LEN_W'(1));

    // Row window for the LOAD about to be entered: first row from the command, else next row.
    assign w_from_idle = (r_state == StIdle);
    assign w_ld_row_y  = w_from_idle ? 32'(i_cmd_ypos) : 32'(r_y) + 32'(r_row) + 32'd1;
    assign w_ld_x      = w_from_idle ? i_cmd_xpos : r_x;
    assign w_ld_wc     = w_from_idle ? w_wc : r_wc;
    assign w_ld_min    = w_ld_row_y * H_DISP + 32'(w_ld_x);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (i_cmd_valid) w_state_next = w_reject ? StDone : StLoad;
            StLoad:   w_state_next = i_cmd_abort ? StDone : StSettle;
            StSettle: w_state_next = i_cmd_abort ? StDone : StWrite;
            StWrite: begin
                if (i_cmd_abort) begin
                    w_state_next = StDone;
                end else if (w_row_end) begin
                    w_state_next = w_last_row ? StDone : StLoad;
                end
            end
            StDone:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_cmd_ready = (r_state == StIdle);
        o_busy      = (r_state != StIdle);
        o_sysLoad   = (r_state == StLoad);
        o_done      = (r_state == StDone);
        o_err       = (r_state == StDone) && r_err;
        o_pix_ready = (r_state == StWrite) && r_mode && (r_pace == '0) && i_sysVaild;
    end

    assign o_sysData        = r_data;
    assign o_sysWriteEnable = r_we;
    assign o_sysAddrMin     = r_addr_min;
    assign o_sysAddrMax     = r_addr_max;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_x        <= '0;
            r_y        <= '0;
            r_wc       <= '0;
            r_hc       <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_mode     <= 1'b0;
            r_color    <= '0;
            r_err      <= 1'b0;
            r_pace     <= '0;
            r_we       <= 1'b0;
            r_data     <= '0;
            r_addr_min <= '0;
            r_addr_max <= '0;
        end else begin
            if (r_state == StIdle && i_cmd_valid) begin
                r_x     <= i_cmd_xpos;
                r_y     <= i_cmd_ypos;
                r_wc    <= w_wc;
                r_hc    <= w_hc;
                r_mode  <= i_cmd_mode;
                r_color <= i_cmd_color;
                r_err   <= w_reject;
                r_row   <= '0;
                r_col   <= '0;
            end
            if ((r_state == StLoad || r_state == StSettle || r_state == StWrite) &&
                i_cmd_abort) begin
                r_err <= 1'b1;
            end
            if (w_state_next == StLoad) begin
                r_addr_min <= w_ld_min;
                r_addr_max <= w_ld_min + 32'(w_ld_wc) - 32'd1;
            end
            if (r_state == StWrite && w_state_next == StLoad) begin
                r_row <= r_row + LEN_W'(1);
                r_col <= '0;
            end else if (w_beat) begin
                r_col <= r_col + LEN_W'(1);
            end
            if (r_state == StSettle) begin
                r_pace <= '0;
            end else if (w_beat) begin
                r_pace <= PACE_RELOAD;
            end else if (r_pace != '0) begin
                r_pace <= r_pace - PACE_W'(1);
            end
            r_we <= w_beat;
            if (w_beat) begin
                r_data <= r_mode ? i_pix_data : r_color;
            end
        end
    end

endmodule

// File: tb/tb_gpu_rect_writer.sv
// Scoreboard bench for gpu_rect_writer: expected row windows and pixels are queued when a
// command is issued and retired as the DUT pulses sysLoad / sysWriteEnable.
module tb_gpu_rect_writer;
    localparam int WR_DIV = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid, cmd_ready, cmd_mode, cmd_abort;
    logic [15:0] cmd_xpos, cmd_ypos, cmd_width, cmd_height;
    logic [23:0] cmd_color, pix_data, sys_data;
    logic        pix_valid, pix_ready, busy, done, err;
    logic        sys_vaild, sys_load, sys_we;
    logic [31:0] sys_addr_min, sys_addr_max;

    int n_checks = 0;
    int n_errors = 0;
    int n_we = 0, n_ld = 0, n_take = 0, cyc = 0, last_we_cyc = 0;
    bit have_last = 0, prev_vaild = 0, prev_take = 0, took = 0;
    bit cur_mode = 0, pix_toggle = 0;
    int last_wc, last_hc;
    bit last_rej;

    logic [23:0] exp_data[$];
    logic [23:0] src_q[$];
    logic [31:0] exp_min[$];
    logic [31:0] exp_max[$];

    gpu_rect_writer dut (
        .i_clk            (clk),
        .i_rstn           (rstn),
        .i_cmd_valid      (cmd_valid),
        .o_cmd_ready      (cmd_ready),
        .i_cmd_xpos       (cmd_xpos),
        .i_cmd_ypos       (cmd_ypos),
        .i_cmd_width      (cmd_width),
        .i_cmd_height     (cmd_height),
        .i_cmd_mode       (cmd_mode),
        .i_cmd_color      (cmd_color),
        .i_cmd_abort      (cmd_abort),
        .i_pix_valid      (pix_valid),
        .i_pix_data       (pix_data),
        .o_pix_ready      (pix_ready),
        .o_busy           (busy),
        .o_done           (done),
        .o_err            (err),
        .i_sysVaild       (sys_vaild),
        .o_sysLoad        (sys_load),
        .o_sysData        (sys_data),
        .o_sysWriteEnable (sys_we),
        .o_sysAddrMin     (sys_addr_min),
        .o_sysAddrMax     (sys_addr_max)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".cmd_ready"}, cmd_ready, 1);
        check_eq({tag, ".busy"}, busy, 0);
        check_eq({tag, ".done"}, done, 0);
        check_eq({tag, ".err"}, err, 0);
        check_eq({tag, ".pix_ready"}, pix_ready, 0);
        check_eq({tag, ".sysLoad"}, sys_load, 0);
        check_eq({tag, ".sysWE"}, sys_we, 0);
        check_eq({tag, ".sysData"}, sys_data, 0);
        check_eq({tag, ".addrMin"}, sys_addr_min, 0);
        check_eq({tag, ".addrMax"}, sys_addr_max, 0);
    endtask

    // Output monitor: retires scoreboard entries and checks strobe legality.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                took = 0;
                prev_vaild = 0;
                prev_take = 0;
            end else begin
                if (sys_load) begin
                    n_ld++;
                    if (exp_min.size() == 0) begin
                        check_eq("load.unexpected", sys_load, 0);
                    end else begin
                        check_eq("load.min", sys_addr_min, exp_min.pop_front());
                        check_eq("load.max", sys_addr_max, exp_max.pop_front());
                    end
                end
                if (sys_we) begin
                    n_we++;
                    if (exp_data.size() == 0) begin
                        check_eq("we.unexpected", sys_we, 0);
                    end else begin
                        check_eq("we.data", sys_data, exp_data.pop_front());
                    end
                    check_eq("we.after_vaild", prev_vaild, 1);
                    if (cur_mode) check_eq("we.after_take", prev_take, 1);
                    if (have_last) check_eq("we.spacing_ok", (cyc - last_we_cyc) >= WR_DIV, 1);
                    have_last = 1;
                    last_we_cyc = cyc;
                end
                took = pix_valid && pix_ready;
                if (took) n_take++;
                prev_vaild = sys_vaild;
                prev_take = took;
            end
        end
    end

    // Pixel source: presents the head of src_q, optionally with random gaps.
    initial begin
        pix_valid = 0;
        pix_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (took && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0 && (!pix_toggle || $urandom_range(0, 1) == 1)) begin
                pix_valid = 1;
                pix_data = src_q[0];
            end else begin
                pix_valid = 0;
            end
        end
    end

    task automatic issue(input int x, input int y, input int w, input int h, input bit mode,
                         input logic [23:0] color, input int max_beats);
        logic [23:0] px;
        last_rej = (x >= 1024) || (y >= 600) || (w == 0) || (h == 0);
        last_wc = (w < 1024 - x) ? w : 1024 - x;
        last_hc = (h < 600 - y) ? h : 600 - y;
        if (!last_rej) begin
            for (int r = 0; r < last_hc; r++) begin
                exp_min.push_back((y + r) * 1024 + x);
                exp_max.push_back((y + r) * 1024 + x + last_wc - 1);
            end
            for (int i = 0; i < last_wc * last_hc; i++) begin
                px = mode ? 24'($urandom) : color;
                if (max_beats < 0 || i < max_beats) exp_data.push_back(px);
                if (mode) src_q.push_back(px);
            end
        end
        cur_mode = mode;
        cmd_xpos = 16'(x);
        cmd_ypos = 16'(y);
        cmd_width = 16'(w);
        cmd_height = 16'(h);
        cmd_mode = mode;
        cmd_color = color;
        cmd_valid = 1;
        @(posedge clk);
        #1 cmd_valid = 0;
    endtask

    task automatic wait_done(input string tag, output bit seen, output int lat);
        seen = 0;
        lat = 0;
        for (int k = 1; k <= 3000 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                lat = k;
            end
        end
        check_eq({tag, ".done_seen"}, seen, 1);
    endtask

    task automatic run_cmd(input string tag, input int x, input int y, input int w, input int h,
                           input bit mode, input logic [23:0] color, input bit toggle);
        bit seen;
        int lat, we0, ld0, tk0;
        pix_toggle = toggle;
        we0 = n_we;
        ld0 = n_ld;
        tk0 = n_take;
        issue(x, y, w, h, mode, color, -1);
        wait_done(tag, seen, lat);
        if (seen) begin
            check_eq({tag, ".err"}, err, last_rej);
            if (last_rej) check_eq({tag, ".reject_latency"}, lat, 1);
        end
        @(negedge clk);
        check_eq({tag, ".cmd_ready"}, cmd_ready, 1);
        check_eq({tag, ".strobes"}, n_we - we0, last_rej ? 0 : last_wc * last_hc);
        check_eq({tag, ".loads"}, n_ld - ld0, last_rej ? 0 : last_hc);
        if (mode) check_eq({tag, ".pix_taken"}, n_take - tk0, last_wc * last_hc);
        check_eq({tag, ".data_left"}, exp_data.size(), 0);
        check_eq({tag, ".load_left"}, exp_min.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit seen;
        int lat, we0, ld0;
        rstn = 0;
        cmd_valid = 0;
        cmd_abort = 0;
        cmd_xpos = '0;
        cmd_ypos = '0;
        cmd_width = '0;
        cmd_height = '0;
        cmd_mode = 0;
        cmd_color = '0;
        sys_vaild = 1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rstn = 1;
        @(negedge clk);

        run_cmd("fill", 10, 2, 4, 3, 0, 24'hA5C3F0, 0);
        run_cmd("clipx", 1020, 0, 8, 1, 1, 24'h0, 0);
        run_cmd("rej_x", 1024, 0, 4, 4, 0, 24'h111111, 0);
        run_cmd("rej_h", 0, 0, 4, 0, 0, 24'h222222, 0);
        run_cmd("clipy", 1000, 598, 30, 5, 0, 24'h123456, 0);

        // Streamed rectangle with a 5-cycle sysVaild stall mid-row.
        fork
            run_cmd("stall", 0, 5, 16, 2, 1, 24'h0, 1);
            begin : stall_drv
                int base;
                base = n_we;
                for (int k = 0; k < 300 && n_we < base + 3; k++) @(negedge clk);
                @(posedge clk);
                #1 sys_vaild = 0;
                repeat (5) @(posedge clk);
                #1 sys_vaild = 1;
            end
        join

        // Abort coinciding with the 4th beat: that beat still strobes, then done with err.
        pix_toggle = 0;
        we0 = n_we;
        ld0 = n_ld;
        issue(100, 10, 10, 1, 0, 24'hC0FFEE, 4);
        for (int k = 0; k < 300 && n_we < we0 + 3; k++) @(negedge clk);
        @(posedge clk);
        #1 cmd_abort = 1;
        @(posedge clk);
        #1 cmd_abort = 0;
        wait_done("abort", seen, lat);
        if (seen) check_eq("abort.err", err, 1);
        @(negedge clk);
        check_eq("abort.cmd_ready", cmd_ready, 1);
        check_eq("abort.strobes", n_we - we0, 4);
        check_eq("abort.loads", n_ld - ld0, last_hc);
        check_eq("abort.data_left", exp_data.size(), 0);

        // Asynchronous reset in the middle of a row, then a normal command.
        issue(0, 0, 20, 3, 0, 24'h0F0F0F, -1);
        repeat (10) @(negedge clk);
        #2 rstn = 0;
        #1 check_reset_outputs("midreset");
        exp_data.delete();
        exp_min.delete();
        exp_max.delete();
        src_q.delete();
        @(posedge clk);
        #1 rstn = 1;
        @(negedge clk);
        run_cmd("post_rst", 5, 7, 3, 2, 0, 24'h00FF00, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
